// File: rtl/gate_self_test.sv
// Built-in self-test for a bank of seven two-input logic gates: walks {a,b} through
// all four input combinations and latches per-gate mismatches against the truth table.
module gate_self_test #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] y_vec,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_LAST = SETTLE_CYCLES[3:0];

    state_e     state_q, state_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:0] fail_q, fail_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] mism_s;
    logic [1:0] vec_next_s;

    // Bit order matches y_vec: AND, OR, NOT, NAND, NOR, XOR, XNOR.
    function automatic logic [6:0] expected_gates(input logic op_a, input logic op_b);
        expected_gates = {~(op_a ^ op_b), op_a ^ op_b, ~(op_a | op_b),
                          ~(op_a & op_b), ~op_a, op_a | op_b, op_a & op_b};
    endfunction

    assign mism_s     = y_vec ^ expected_gates(a_q, b_q);
    assign vec_next_s = vec_q + 2'd1;

    // Next-state and output computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                vec_d  = 2'd0;
                cnt_d  = 4'd0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    fail_d  = 7'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d  = 4'd0;
                    fail_d = fail_q | mism_s;
                    if (vec_q == 2'd3) begin
                        // Last vector sampled: result is final this edge.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = ((fail_q | mism_s) == 7'd0);
                    end else begin
                        vec_d = vec_next_s;
                        a_d   = vec_next_s[1];
                        b_d   = vec_next_s[0];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                // Stimulus holds through DONE and returns to 00 as IDLE begins.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                a_d     = 1'b0;
                b_d     = 1'b0;
                vec_d   = 2'd0;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
                vec_d   = 2'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 7'd0;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_q;
    assign vec_idx   = vec_q;

endmodule

// File: tb/tb_gate_self_test.sv
// Bench for gate_self_test: three instances (settle 0, 1, 15) fed by a gate model with
// injectable faults; expectations come from the truth table and the run schedule.
module tb_gate_self_test;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_r;
    logic [6:0] y_w    [3];
    logic       a_w    [3];
    logic       b_w    [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [6:0] fm_w   [3];
    logic [1:0] vidx_w [3];

    int         mode   [3];
    logic [6:0] flip   [3][4];
    int         checks;
    int         errors;

    gate_self_test #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .y_vec(y_w[0]),
        .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .fail_mask(fm_w[0]), .vec_idx(vidx_w[0]));

    gate_self_test #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .y_vec(y_w[1]),
        .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .fail_mask(fm_w[1]), .vec_idx(vidx_w[1]));

    gate_self_test #(.SETTLE_CYCLES(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .y_vec(y_w[2]),
        .a(a_w[2]), .b(b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .fail_mask(fm_w[2]), .vec_idx(vidx_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate truth table from arithmetic on 0/1 operands; bit order AND,OR,NOT,NAND,NOR,XOR,XNOR.
    function automatic logic [6:0] truth(input logic ta, input logic tb);
        int ia, ib, g_and, g_or, g_xor;
        ia    = int'(ta);
        ib    = int'(tb);
        g_and = ia * ib;
        g_or  = (ia + ib > 0) ? 1 : 0;
        g_xor = (ia + ib) % 2;
        truth = {g_xor == 0, g_xor == 1, g_or == 0, g_and == 0, ia == 0, g_or == 1, g_and == 1};
    endfunction

    // Gate bank model with fault injection: 1 = XOR stuck at 0, 2 = AND/NOR swapped, 3 = random flips.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            logic [6:0] t;
            t = truth(a_w[k], b_w[k]);
            y_w[k] = t;
            case (mode[k])
                1: y_w[k][5] = 1'b0;
                2: begin
                    y_w[k][0] = t[4];
                    y_w[k][4] = t[0];
                end
                3: y_w[k] = t ^ flip[k][{a_w[k], b_w[k]}];
                default: y_w[k] = t;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; runs one test on instance k and checks every cycle through the following IDLE cycle.
    task automatic do_run(input int k, input int s, input logic [6:0] exp_mask, input bit hold_start);
        logic [1:0] v;
        start_r[k] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4 * (s + 1); c++) begin
            @(negedge clk);
            if (!hold_start) start_r[k] = 1'b0;
            v = 2'((c - 1) / (s + 1));
            check("run_status", {busy_w[k], done_w[k], vidx_w[k], a_w[k], b_w[k]},
                  {1'b1, 1'b0, v, v[1], v[0]});
            if (c == 1) check("mask_cleared_at_start", fm_w[k], 7'd0);
        end
        @(negedge clk);
        check("done_status", {busy_w[k], done_w[k], vidx_w[k], a_w[k], b_w[k]}, 6'b01_11_11);
        check("done_mask", fm_w[k], exp_mask);
        check("done_pass", pass_w[k], exp_mask == 7'd0);
        @(negedge clk);
        check("idle_status", {busy_w[k], done_w[k], vidx_w[k], a_w[k], b_w[k]}, 6'd0);
        check("held_mask", fm_w[k], exp_mask);
        check("held_pass", pass_w[k], exp_mask == 7'd0);
    endtask

    initial begin
        int         s_of [3];
        int         k;
        logic [6:0] exp_mask;
        s_of[0] = 0; s_of[1] = 1; s_of[2] = 15;
        checks = 0;
        errors = 0;
        start_r = 3'd0;
        for (int i = 0; i < 3; i++) begin
            mode[i] = 0;
            for (int j = 0; j < 4; j++) flip[i][j] = 7'd0;
        end
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < 3; i++)
            check("reset_outputs", {a_w[i], b_w[i], vidx_w[i], busy_w[i], done_w[i], pass_w[i], fm_w[i]}, 14'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        do_run(0, 0, 7'd0, 1'b0);
        mode[1] = 1;
        do_run(1, 1, 7'b0100000, 1'b0);
        mode[0] = 2;
        do_run(0, 0, 7'b0010001, 1'b0);
        mode[0] = 0;
        do_run(0, 0, 7'd0, 1'b0);

        // start held high: back-to-back runs with one IDLE cycle between
        for (int r = 0; r < 3; r++) do_run(0, 0, 7'd0, 1'b1);
        start_r[0] = 1'b0;

        do_run(2, 15, 7'd0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(0, 1));
            mode[k] = 3;
            exp_mask = 7'd0;
            for (int j = 0; j < 4; j++) begin
                flip[k][j] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
                exp_mask |= flip[k][j];
            end
            do_run(k, s_of[k], exp_mask, 1'b0);
            mode[k] = 0;
        end

        // Reset in the middle of vector 2 on the settle-1 instance
        start_r[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[1] = 1'b0;
        for (int i = 0; i < 40 && vidx_w[1] != 2'd2; i++) @(negedge clk);
        check("reached_vec2", vidx_w[1], 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {a_w[1], b_w[1], vidx_w[1], busy_w[1], done_w[1], pass_w[1], fm_w[1]}, 14'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {busy_w[1], done_w[1]}, 2'd0);
        end
        do_run(1, 1, 7'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_self_test.md
GATE_SELF_TEST -- requirements
Module: gate_self_test

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 1, meaning extra cycles each vector is held before sampling (legal 0..15).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL provide port start  input  1  request a self-test run; sampled only in IDLE.
REQ-005 SHALL provide port y_vec  input  7  gate outputs under test: [0] AND, [1] OR, [2] NOT, [3] NAND, [4] NOR, [5] XOR, [6] XNOR.
REQ-006 SHALL provide port a  output  1  stimulus operand A, registered.
REQ-007 SHALL provide port b  output  1  stimulus operand B, registered (NOT gate consumes a only).
REQ-008 SHALL provide port busy  output  1  high while a run is in progress.
REQ-009 SHALL provide port done  output  1  single-cycle pulse at run completion.
REQ-010 SHALL provide port pass  output  1  result of the last completed run; high iff no mismatch.
REQ-011 SHALL provide port fail_mask  output  7  sticky per-gate mismatch flags, same bit order as y_vec.
REQ-012 SHALL provide port vec_idx  output  2  index of the vector currently driven.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after vector 3 is sampled; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL apply vectors in fixed order {a,b} = 00, 01, 10, 11, with vec_idx = 0, 1, 2, 3 respectively.
REQ-015 SHALL, on the edge that samples start=1 in IDLE (cycle T), clear fail_mask to 0, set vec_idx=0, drive {a,b}=00, and assert busy from cycle T+1.
REQ-016 SHALL hold vector k on a/b during cycles T+1+k*(SETTLE_CYCLES+1) through T+(k+1)*(SETTLE_CYCLES+1), using an internal settle counter of width 4.
REQ-017 SHALL sample y_vec on the rising edge that ends the last hold cycle of each vector, then advance to the next vector on that same edge.
REQ-018 SHALL compute expected values from the driven a,b: a&b, a|b, ~a, ~(a&b), ~(a|b), a^b, ~(a^b).
REQ-019 SHALL set fail_mask[i] when sampled y_vec[i] differs from expected[i]; bits never clear during a run.
REQ-020 SHALL assert done for exactly one cycle, cycle T+1+4*(SETTLE_CYCLES+1) (DONE state), with busy=0 in that cycle.
REQ-021 SHALL update pass = (final fail_mask == 0) on entry to DONE and hold pass and fail_mask until the next accepted start or reset.
REQ-022 SHALL ignore start while in RUN or DONE; no restart, no clearing of results.
REQ-023 SHALL hold a, b, vec_idx at their last values in DONE, and drive 00, 0 in IDLE.
REQ-024 SHALL treat y_vec X/Z as mismatch is NOT required; y_vec is assumed a clean 0/1 input for RTL purposes.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, a=0, b=0, vec_idx=0, busy=0, done=0, pass=0, fail_mask=0, settle counter=0, independent of clk.
REQ-026 SHALL abort any run in progress on reset assertion with no done pulse and no pass update; operation resumes only on a start sampled after rst_n rises.

Verification
REQ-027 SHALL cover: SETTLE_CYCLES=0, correct gates feeding y_vec, start pulse at cycle T -> vectors 00,01,10,11 in cycles T+1..T+4, done at T+5, pass=1, fail_mask=0000000.
REQ-028 SHALL cover: SETTLE_CYCLES=1, y_vec[5] stuck at 0 -> done at T+9, pass=0, fail_mask=0100000.
REQ-029 SHALL cover: SETTLE_CYCLES=0, AND and NOR outputs swapped -> fail_mask=0010001, pass=0; then rerun with correct gates -> fail_mask cleared at start, pass=1.
REQ-030 SHALL cover: start held high continuously -> runs back-to-back with one IDLE cycle between done and next busy; start during RUN/DONE causes no restart.
REQ-031 SHALL cover: rst_n pulsed low mid-vector 2 -> all outputs zero immediately (asynchronous), no done pulse, next start yields full normal run.
REQ-032 SHALL cover: SETTLE_CYCLES=15 -> each vector held 16 cycles, done at T+65, vec_idx monotonic 0..3.
